// File: rtl/cpu_pkg.sv
// Shared pipeline types: forwarding selects, divider sequencer state.
// Imported by the hazard controller and its divider sequencer.
package cpu_pkg;

  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

endpackage

// File: rtl/hazard_div_seq.sv
// UDIV sequencer: holds the front of the pipe while the divider
// iterates in Execute, then pulses done for one cycle.
module hazard_div_seq
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  output logic div_stall,
  output logic div_done,
  output logic div_busy
);

  localparam logic [DIV_CNT_W-1:0] CNT_INIT =
    DIV_CNT_W'(DIV_CYCLES - 2);

  div_state_t           state, state_n;
  logic [DIV_CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Start cycle stalls as Mealy output; start is ignored once BUSY
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_stall = 1'b0;
    div_done  = 1'b0;
    div_busy  = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_start) begin
          div_stall = 1'b1;
          div_busy  = 1'b1;
          state_n   = BUSY;
          cnt_n     = CNT_INIT;
        end
      end
      BUSY: begin
        div_busy = 1'b1;
        if (cnt != '0) begin
          div_stall = 1'b1;
          cnt_n     = cnt - 1'b1;
        end else begin
          div_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard control: Execute forwarding, load-use stall,
// branch flush and UDIV front-end hold.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int DIV_CYCLES    = 16,
  parameter int ZERO_REG_HARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  input  logic [REG_ADDR_W-1:0] RS1_E,
  input  logic [REG_ADDR_W-1:0] RS2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  DivStartE,
  output logic [1:0]            ForwardA_E,
  output logic [1:0]            ForwardB_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  BubbleM,
  output logic                  DivBusy,
  output logic                  DivDoneE
);

  localparam bit ZERO_HARD = (ZERO_REG_HARD != 0);

  logic div_stall, div_done, div_busy;
  logic lu_hit, lu, br;

  hazard_div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .div_start(DivStartE),
    .div_stall(div_stall),
    .div_done (div_done),
    .div_busy (div_busy)
  );

  function automatic fwd_sel_t fwd(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (ZERO_HARD && rs == '0)
      return FWD_RF;
    if (RegWriteM && RD_M == rs)
      return FWD_M;
    if (RegWriteW && RD_W == rs)
      return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic src_hit(
    input logic [REG_ADDR_W-1:0] rs
  );
    return (RD_E == rs) && !(ZERO_HARD && rs == '0);
  endfunction

  always_comb begin
    lu_hit = ResultSrcE && (src_hit(RS1_D) || src_hit(RS2_D));
    // An in-flight UDIV must never be killed or re-stalled by hazards
    lu = lu_hit && !div_busy;
    br = PCSrcE && !div_busy;
  end

  // Reset forces every output low, including the combinational ones
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    BubbleM    = 1'b0;
    DivBusy    = 1'b0;
    DivDoneE   = 1'b0;
    if (!rst) begin
      ForwardA_E = fwd(RS1_E);
      ForwardB_E = fwd(RS2_E);
      StallF     = div_stall || (lu && !br);
      StallD     = div_stall || (lu && !br);
      StallE     = div_stall;
      FlushD     = br;
      FlushE     = br || lu;
      BubbleM    = div_stall;
      DivBusy    = div_busy;
      DivDoneE   = div_done;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a cycle-position
// reference model of the UDIV occupancy of Execute.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int DC = 4;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic          rwm, rww, rse, pcs, div;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, bm, busy, done;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0;
  logic [AW-1:0] RD_E = '0, RD_M = '0, RD_W = '0;
  logic RegWriteM = 0, RegWriteW = 0, ResultSrcE = 0;
  logic PCSrcE = 0, DivStartE = 0;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic StallF, StallD, StallE, FlushD, FlushE, BubbleM;
  logic DivBusy, DivDoneE;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int pos = -1;
  outs_t expq[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(AW), .DIV_CYCLES(DC), .ZERO_REG_HARD(1)
  ) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .DivStartE(DivStartE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .DivBusy(DivBusy), .DivDoneE(DivDoneE)
  );

  always @(negedge clk)
    if (!rst)
      assert (!(PCSrcE && DivStartE))
        else $error("illegal PCSrcE together with DivStartE");

  function automatic logic [1:0] ref_fwd(input stim_t s,
                                         input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (s.rwm && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // cur: this cycle's position of the UDIV inside Execute (-1 = none)
  function automatic outs_t ref_out(input stim_t s, input int cur);
    outs_t o;
    logic lu;
    o = '0;
    if (s.rst) return o;
    o.fa = ref_fwd(s, s.rs1e);
    o.fb = ref_fwd(s, s.rs2e);
    lu = s.rse && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (cur >= 0) begin
      o.busy = 1'b1;
      o.done = (cur == DC - 1);
      o.sf = !o.done; o.sd = !o.done; o.se = !o.done; o.bm = !o.done;
    end else begin
      o.fd = s.pcs;
      o.fe = s.pcs || lu;
      o.sf = lu && !s.pcs;
      o.sd = lu && !s.pcs;
    end
    return o;
  endfunction

  task automatic apply(input stim_t s);
    int cur;
    @(posedge clk);
    #1;
    rst = s.rst;
    RS1_D = s.rs1d; RS2_D = s.rs2d; RS1_E = s.rs1e; RS2_E = s.rs2e;
    RD_E = s.rde; RD_M = s.rdm; RD_W = s.rdw;
    RegWriteM = s.rwm; RegWriteW = s.rww; ResultSrcE = s.rse;
    PCSrcE = s.pcs; DivStartE = s.div;
    if (s.rst) cur = -1;
    else if (pos >= 0) cur = pos;
    else cur = s.div ? 0 : -1;
    expq.push_back(ref_out(s, cur));
    if (cur < 0 || cur == DC - 1) pos = -1;
    else pos = cur + 1;
  endtask

  initial begin : monitor
    outs_t act, exp_o;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        exp_o = expq.pop_front();
        act = {ForwardA_E, ForwardB_E, StallF, StallD, StallE,
               FlushD, FlushE, BubbleM, DivBusy, DivDoneE};
        checks++;
        if (act !== exp_o) begin
          failures++;
          $display("FAIL outs cycle %0d: got fa=%b fb=%b sf%b sd%b se%b fd%b fe%b bm%b busy%b done%b want fa=%b fb=%b sf%b sd%b se%b fd%b fe%b bm%b busy%b done%b",
            ncyc, act.fa, act.fb, act.sf, act.sd, act.se, act.fd,
            act.fe, act.bm, act.busy, act.done, exp_o.fa, exp_o.fb,
            exp_o.sf, exp_o.sd, exp_o.se, exp_o.fd, exp_o.fe,
            exp_o.bm, exp_o.busy, exp_o.done);
        end
        ncyc++;
      end
    end
  end

  initial begin : stim
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    apply(s);
    apply(s);
    s.rst = 1'b0;
    apply(s);
    // forwarding priority and zero register
    s.rs1e = 3; s.rdm = 3; s.rwm = 1; s.rdw = 3; s.rww = 1;
    apply(s);
    s.rwm = 0;
    apply(s);
    s.rs1e = 0;
    apply(s);
    s = '0;
    s.rs2e = 7; s.rdw = 7; s.rww = 1;
    apply(s);
    // load-use then clear
    s = '0;
    s.rse = 1; s.rde = 5; s.rs2d = 5;
    apply(s);
    s.rse = 0;
    apply(s);
    s.rse = 1; s.rde = 0; s.rs1d = 0;
    apply(s);
    // branch beats load-use
    s = '0;
    s.rse = 1; s.rde = 5; s.rs1d = 5; s.pcs = 1;
    apply(s);
    // UDIV with a load-use pending throughout
    s = '0;
    s.div = 1; s.rse = 1; s.rde = 6; s.rs1d = 6;
    repeat (DC) apply(s);
    // back-to-back UDIV
    repeat (DC) apply(s);
    s = '0;
    apply(s);
    // reset in the second cycle of a UDIV
    s.div = 1;
    apply(s);
    s.rst = 1;
    apply(s);
    s = '0;
    apply(s);
    apply(s);
    for (int i = 0; i < 600; i++) begin
      s.rst  = ($urandom_range(0, 49) == 0);
      s.rs1d = AW'($urandom_range(0, 3));
      s.rs2d = AW'($urandom_range(0, 3));
      s.rs1e = AW'($urandom_range(0, 3));
      s.rs2e = AW'($urandom_range(0, 3));
      s.rde  = AW'($urandom_range(0, 3));
      s.rdm  = AW'($urandom_range(0, 3));
      s.rdw  = AW'($urandom_range(0, 3));
      s.rwm  = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1));
      s.rse  = 1'($urandom_range(0, 1));
      if (pos >= 0) begin
        s.div = 1'b1;
        s.pcs = 1'b0;
      end else begin
        s.div = ($urandom_range(0, 7) == 0);
        s.pcs = s.div ? 1'b0 : ($urandom_range(0, 4) == 0);
      end
      apply(s);
    end
    s = '0;
    apply(s);
    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d pending, want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the Fetch/Decode/Execute/Memory/Writeback pipeline.
- Generates the Execute-stage operand forwarding selects.
- Detects load-use hazards and branch redirects, and drives the stage stall/flush controls.
- Sequences the multicycle UDIV operation by holding the front of the pipeline while the divider iterates in Execute.

Parameters:
REG_ADDR_W, 5, width of register specifiers (RS1/RS2/RD).
DIV_CYCLES, 16, total cycles a UDIV occupies Execute; legal range 2..255.
ZERO_REG_HARD, 1, if 1 then register address 0 is never forwarded and never causes a load-use stall.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous reset, active-high.
RS1_D  in  REG_ADDR_W  source 1 of the instruction in Decode.
RS2_D  in  REG_ADDR_W  source 2 of the instruction in Decode.
RS1_E  in  REG_ADDR_W  source 1 of the instruction in Execute.
RS2_E  in  REG_ADDR_W  source 2 of the instruction in Execute.
RD_E  in  REG_ADDR_W  destination of the instruction in Execute.
RD_M  in  REG_ADDR_W  destination of the instruction in Memory.
RD_W  in  REG_ADDR_W  destination of the instruction in Writeback.
RegWriteM  in  1  Memory-stage instruction writes the register file.
RegWriteW  in  1  Writeback-stage instruction writes the register file.
ResultSrcE  in  1  Execute-stage instruction is a load.
PCSrcE  in  1  branch taken / PC redirect from Execute.
DivStartE  in  1  a valid UDIV is in Execute.
ForwardA_E  out  2  operand A select: 00 = register file, 10 = ALU_ResultM, 01 = ResultW.
ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
StallF  out  1  hold the PC.
StallD  out  1  hold the IF/ID register.
StallE  out  1  hold the ID/EX register.
FlushD  out  1  clear the IF/ID register.
FlushE  out  1  clear the ID/EX register (inserts a bubble).
BubbleM  out  1  clear the EX/MEM register (inserts a bubble).
DivBusy  out  1  divider sequencer is not IDLE.
DivDoneE  out  1  single-cycle pulse: the UDIV result is valid in Execute this cycle.

Behaviour:
- Reset: while rst=1, every output is 0, the FSM is IDLE and the counter is 0. Reset taking effect mid-UDIV aborts the sequence and releases all stalls immediately.
- Forwarding (combinational), evaluated for A using RS1_E and for B using RS2_E:
  - 10 if RegWriteM and RD_M==RSx_E.
  - else 01 if RegWriteW and RD_W==RSx_E.
  - else 00.
  - Memory has priority over Writeback.
  - With ZERO_REG_HARD=1, RSx_E==0 always gives 00.
- Load-use (combinational): lu = ResultSrcE & (RD_E==RS1_D | RD_E==RS2_D), with the address-0 rule applied.
  - lu forces StallF=StallD=1 and FlushE=1 for exactly that cycle.
- Branch: PCSrcE forces FlushD=1 and FlushE=1 in the same cycle. Branch takes precedence over lu: StallF/StallD are not asserted when PCSrcE=1.
- Divider FSM: states IDLE, BUSY; 8-bit down-counter cnt.
  - IDLE with DivStartE=1 (cycle t): Mealy stall, so StallF=StallD=StallE=1 and BubbleM=1 in cycle t. Next state BUSY, cnt <= DIV_CYCLES-2.
  - BUSY with cnt!=0: StallF/D/E=1, BubbleM=1, cnt <= cnt-1.
  - BUSY with cnt==0: DivDoneE=1, no stalls, BubbleM=0, next state IDLE. The UDIV advances to Memory at the following edge.
  - Net effect: stalls are asserted for cycles t..t+DIV_CYCLES-2, DivDoneE is high in cycle t+DIV_CYCLES-1, and UDIV spends DIV_CYCLES cycles in Execute.
  - DivStartE remains high throughout BUSY. It is ignored in BUSY, so the sequence does not retrigger.
  - A back-to-back UDIV starts a new sequence in the cycle after DivDoneE.
- While DivBusy=1, or in the IDLE start cycle:
  - lu is suppressed, and FlushE/FlushD are forced to 0, so the UDIV is never killed.
  - Forwarding selects keep being computed from the live inputs.
- PCSrcE asserted together with DivStartE is illegal, since UDIV is not a branch. The bench flags it with an assertion; the RTL gives divider priority.
- DivBusy = (state==BUSY) | (state==IDLE & DivStartE).

Decomposition:
- Add to the shared cpu_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - div_state_t enum: IDLE, BUSY.
  - DIV_CNT_W constant = 8.
- Sub-module hazard_div_seq holds the FSM and counter and outputs div_stall and div_done. The top level contains forwarding, load-use and flush priority logic.

Test Plan:
- RS1_E=3, RD_M=3, RegWriteM=1, RD_W=3, RegWriteW=1 -> ForwardA_E=10. Then RegWriteM=0 -> 01. Then RS1_E=0 -> 00.
- ResultSrcE=1, RD_E=5, RS2_D=5 -> StallF=StallD=FlushE=1 for one cycle. Next cycle (ResultSrcE=0) all clear.
- PCSrcE=1 with a simultaneous load-use -> FlushD=FlushE=1, StallF=StallD=0.
- DIV_CYCLES=4, DivStartE held high 4 cycles from t -> stalls and BubbleM high at t, t+1, t+2; DivDoneE high only at t+3; DivBusy high at t..t+3.
- Load-use condition present during UDIV BUSY -> FlushE stays 0 and StallE=1 until DivDoneE.
- rst pulsed at t+1 of a UDIV -> all outputs 0 asynchronously. After release with DivStartE=0: IDLE, no stalls.
